frog_btn_conditioner: RTL

//  Sits between the raw board push-buttons and the frog movement block.

---
 rtl/frog_pkg.sv | 32 +++
 rtl/btn_debounce.sv | 61 ++++++
 rtl/frog_btn_conditioner.sv | 121 ++++++++++++
 3 files changed

// File: rtl/frog_pkg.sv
// Shared constants for the frog button conditioner: button index map,
// default timing parameters and the request priority picker.
package frog_pkg;

   // Bit positions inside every 4-bit button vector ({left,right,down,up})
   localparam int unsigned BTN_UP    = 32'd0;
   localparam int unsigned BTN_DOWN  = 32'd1;
   localparam int unsigned BTN_RIGHT = 32'd2;
   localparam int unsigned BTN_LEFT  = 32'd3;

   // Default debounce window and auto-repeat period
   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 32'd1_000_000;
   localparam int unsigned DEFAULT_REPEAT_FRAMES   = 32'd16;

   // Pick the single highest-priority pending bit: up > down > right > left
   function automatic logic [3:0] pick_req(input logic [3:0] pend);
      logic [3:0] res;
      res = 4'b0000;
      if (pend[BTN_UP])
         res[BTN_UP] = 1'b1;
      else if (pend[BTN_DOWN])
         res[BTN_DOWN] = 1'b1;
      else if (pend[BTN_RIGHT])
         res[BTN_RIGHT] = 1'b1;
      else if (pend[BTN_LEFT])
         res[BTN_LEFT] = 1'b1;
      else
         res = 4'b0000;
      return res;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: two-flop synchroniser, polarity normalisation,
// stability counter and a one-cycle pulse on each accepted press.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 32'd1_000_000,
   parameter int unsigned CNT_W           = 32'd20,
   parameter bit          RAW_ACTIVE_LOW  = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_raw,
   output logic o_stable,
   output logic o_rise
);

   // Pin level that means "not pressed"
   localparam logic RELEASED_LVL = RAW_ACTIVE_LOW;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

   logic             r_sync1;
   logic             r_sync2;
   logic             w_synced;
   logic [CNT_W-1:0] r_cnt;
   logic             r_stable;
   logic             r_rise;

   // Two-flop synchroniser, resetting to the released pin level
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1 <= RELEASED_LVL;
         r_sync2 <= RELEASED_LVL;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
      end
   end

   assign w_synced = RAW_ACTIVE_LOW ? ~r_sync2 : r_sync2;

   // Accept a new level only after it has held for the full debounce window
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt    <= {CNT_W{1'b0}};
         r_stable <= 1'b0;
         r_rise   <= 1'b0;
      end else if (w_synced == r_stable) begin
         r_cnt  <= {CNT_W{1'b0}};
         r_rise <= 1'b0;
      end else if (r_cnt == CNT_LAST) begin
         r_stable <= w_synced;
         r_cnt    <= {CNT_W{1'b0}};
         r_rise   <= w_synced;
      end else begin
         r_cnt  <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         r_rise <= 1'b0;
      end
   end

   assign o_stable = r_stable;
   assign o_rise   = r_rise;

endmodule

// File: rtl/frog_btn_conditioner.sv
// Button conditioner for the frog movement block. Debounces four direction
// buttons and turns each press into one held, active-low hop request that is
// released when the frog samples it on an enabled animation strobe.
// Optional build macro AUTO_REPEAT_EN: re-issue a held button every
// REPEAT_FRAMES enabled strobes.
module frog_btn_conditioner
   import frog_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned CNT_W           = 32'd20,
   parameter bit          RAW_ACTIVE_LOW  = 1'b1,
   parameter int unsigned REPEAT_FRAMES   = DEFAULT_REPEAT_FRAMES
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [3:0] i_btn_raw,
   input  logic       i_ani_stb,
   input  logic       i_animate,
   input  logic       i_dead,
   output logic       o_up_btn,
   output logic       o_down_btn,
   output logic       o_right_btn,
   output logic       o_left_btn,
   output logic [3:0] o_btn_state
);

   logic [3:0] w_stable;
   logic [3:0] w_rise;
   logic [3:0] w_rep_hit;
   logic [3:0] w_set;
   logic       w_frame;
   logic       w_sample;
   logic [3:0] r_pending;
   logic [3:0] r_req;

   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : g_btn
         btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .RAW_ACTIVE_LOW  (RAW_ACTIVE_LOW)
         ) u_deb (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_raw    (i_btn_raw[g]),
            .o_stable (w_stable[g]),
            .o_rise   (w_rise[g])
         );
      end
   endgenerate

   assign w_frame  = i_ani_stb & i_animate;
   assign w_sample = (r_req != 4'b0000) & w_frame;

`ifdef AUTO_REPEAT_EN
   localparam int unsigned REP_W = $clog2(REPEAT_FRAMES + 32'd1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES - 32'd1);

   logic [REP_W-1:0] r_rep_cnt [4];

   // Count enabled frames while a button is held; wrap when the period is reached
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < 4; i++) begin
         if (i_rst || i_dead || !w_stable[i]) begin
            r_rep_cnt[i] <= {REP_W{1'b0}};
         end else if (w_frame) begin
            if (r_rep_cnt[i] == REP_LAST)
               r_rep_cnt[i] <= {REP_W{1'b0}};
            else
               r_rep_cnt[i] <= r_rep_cnt[i] + {{(REP_W-1){1'b0}}, 1'b1};
         end else begin
            r_rep_cnt[i] <= r_rep_cnt[i];
         end
      end
   end

   // A repeat fires on the frame that completes the period
   always_comb begin
      w_rep_hit = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         if (w_stable[i] && w_frame && (r_rep_cnt[i] == REP_LAST))
            w_rep_hit[i] = 1'b1;
         else
            w_rep_hit[i] = 1'b0;
      end
   end
`else
   assign w_rep_hit = 4'b0000;
`endif

   assign w_set = w_rise | w_rep_hit;

   // Pending/request arbitration; death clears everything and wins over issue/consume
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pending <= 4'b0000;
         r_req     <= 4'b0000;
      end else if (i_dead) begin
         r_pending <= 4'b0000;
         r_req     <= 4'b0000;
      end else if ((r_req == 4'b0000) && (r_pending != 4'b0000)) begin
         // Losing simultaneous presses are dropped; only fresh edges survive
         r_req     <= pick_req(r_pending);
         r_pending <= w_set;
      end else if (w_sample) begin
         r_req     <= 4'b0000;
         r_pending <= r_pending | w_set;
      end else begin
         r_req     <= r_req;
         r_pending <= r_pending | w_set;
      end
   end

   assign o_up_btn    = ~r_req[BTN_UP];
   assign o_down_btn  = ~r_req[BTN_DOWN];
   assign o_right_btn = ~r_req[BTN_RIGHT];
   assign o_left_btn  = ~r_req[BTN_LEFT];
   assign o_btn_state = w_stable;

endmodule
